mux_arbiter: RTL and testbench

//  Registered arbiter sharing one resource (bus/memory port/ALU mux input) among NUM_REQ requesters.

---
 rtl/mux_arbiter_if.sv | 23 ++
 rtl/mux_arbiter.sv | 143 ++++++++++++++
 tb/tb_mux_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between requesting units and the arbiter.
// master = requester side, slave = arbiter side.
interface mux_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [0:NUM_REQ-1] req;
  logic               rr_mode;
  logic [0:NUM_REQ-1] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               to_err;

  modport master (
    output req, rr_mode,
    input  gnt, gnt_idx, gnt_vld, to_err
  );

  modport slave (
    input  req, rr_mode,
    output gnt, gnt_idx, gnt_vld, to_err
  );
endinterface

// File: rtl/mux_arbiter.sv
// Registered fixed/round-robin arbiter driving a shared mux sel/enb.
// Define ARB_TIMEOUT_EN to bound grant length and mask offenders.
module mux_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      IDX_W != $clog2(NUM_REQ) ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mux_arbiter: bad parameters");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [0:NUM_REQ-1] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic [0:NUM_REQ-1] elig;
  logic               to_hit;
  logic               owner_req;

  assign owner_req = bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:NUM_REQ-1] mask_q, mask_d;
  logic               to_err_q;

  assign elig   = bus.req & ~mask_q;
  assign to_hit = (state_q == GRANT) && owner_req &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // grant-length counter and per-requester timeout mask
  always_comb begin
    cnt_d  = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    mask_d = mask_q & bus.req;
    if (to_hit) mask_d[idx_q] = 1'b1;
  end

  // timeout bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mask_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      to_err_q <= to_hit;
    end
  end

  assign bus.to_err = to_err_q;
`else
  assign elig       = bus.req;
  assign to_hit     = 1'b0;
  assign bus.to_err = 1'b0;
`endif

  // winner pick: descending loops so the
  // highest-priority candidate is written last
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    if (!bus.rr_mode) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win     = IDX_W'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (elig[(int'(last_q) + k) % NUM_REQ]) begin
          win     = IDX_W'((int'(last_q) + k) % NUM_REQ);
          win_vld = 1'b1;
        end
      end
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_vld) state_d = GRANT;
      GRANT: if (!owner_req || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    gnt_d  = gnt_q;
    idx_d  = idx_q;
    last_d = last_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d[win] = 1'b1;
          idx_d      = win;
          last_d     = win;
        end
      end
      GRANT: begin
        if (!owner_req || to_hit) gnt_d = '0;
      end
      default: gnt_d = '0;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = |gnt_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter.
// Timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

  mux_arbiter #(
    .NUM_REQ(4),
    .IDX_W(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {gnt[0:3], gnt_idx, gnt_vld, to_err}
  logic [7:0] o;
  assign o = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.to_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.rr_mode = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rr_mode = 1'b0;
    bus.req = 4'b1111;
    step();
    checks++;
    if (o !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL rst_c1 got=%b exp=%b", o, 8'b0000_00_0_0);
    end
    step();
    checks++;
    if (o !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL rst_c2 got=%b exp=%b", o, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL rst_first got=%b exp=%b", o, 8'b1000_00_1_0);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    bus.rr_mode = 1'b0;
    bus.req = 4'b1011;
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL fix_g0 got=%b exp=%b", o, 8'b1000_00_1_0);
    end
    step();
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL fix_hold got=%b exp=%b", o, 8'b1000_00_1_0);
    end
    bus.req = 4'b0011;
    step();
    checks++;
    if (o !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL fix_rel got=%b exp=%b", o, 8'b0000_00_0_0);
    end
    step();
    checks++;
    if (o !== 8'b0010_10_1_0) begin
      failures++;
      $display("FAIL fix_g2 got=%b exp=%b", o, 8'b0010_10_1_0);
    end
    bus.req = 4'b1011;
    step();
    checks++;
    if (o !== 8'b0010_10_1_0) begin
      failures++;
      $display("FAIL fix_nopre got=%b exp=%b", o, 8'b0010_10_1_0);
    end
    bus.req = 4'b1001;
    step();
    checks++;
    if (o !== 8'b0000_10_0_0) begin
      failures++;
      $display("FAIL fix_rel2 got=%b exp=%b", o, 8'b0000_10_0_0);
    end
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL fix_regnt0 got=%b exp=%b", o, 8'b1000_00_1_0);
    end
  endtask

  task automatic test_round_robin();
    logic [0:3] oh;
    logic [7:0] exp;
    int e;
    do_reset();
    bus.rr_mode = 1'b1;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e = n % 4;
      oh = '0;
      oh[e] = 1'b1;
      exp = {oh, 2'(e), 1'b1, 1'b0};
      step();
      checks++;
      if (o !== exp) begin
        failures++;
        $display("FAIL rr_grant%0d got=%b exp=%b", n, o, exp);
      end
      step();
      step();
      bus.req[e] = 1'b0;
      exp = {4'b0000, 2'(e), 1'b0, 1'b0};
      step();
      checks++;
      if (o !== exp) begin
        failures++;
        $display("FAIL rr_bubble%0d got=%b exp=%b", n, o, exp);
      end
      bus.req[e] = 1'b1;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.rr_mode = 1'b1;
    bus.req = 4'b0001;
    step();
    checks++;
    if (o !== 8'b0001_11_1_0) begin
      failures++;
      $display("FAIL wrap_g3 got=%b exp=%b", o, 8'b0001_11_1_0);
    end
    bus.req = 4'b0000;
    step();
    checks++;
    if (o !== 8'b0000_11_0_0) begin
      failures++;
      $display("FAIL wrap_rel got=%b exp=%b", o, 8'b0000_11_0_0);
    end
    bus.req = 4'b1000;
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL wrap_g0 got=%b exp=%b", o, 8'b1000_00_1_0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rr_mode = 1'b1;
    bus.req = 4'b0010;
    step();
    checks++;
    if (o !== 8'b0010_10_1_0) begin
      failures++;
      $display("FAIL rmid_g2 got=%b exp=%b", o, 8'b0010_10_1_0);
    end
    rst = 1'b1;
    bus.req = 4'b1111;
    step();
    checks++;
    if (o !== 8'b0000_00_0_0) begin
      failures++;
      $display("FAIL rmid_drop got=%b exp=%b", o, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL rmid_g0 got=%b exp=%b", o, 8'b1000_00_1_0);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.rr_mode = 1'b0;
    bus.req = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (o !== 8'b1000_00_1_0) begin
        failures++;
        $display("FAIL to_own%0d got=%b exp=%b", i, o, 8'b1000_00_1_0);
      end
    end
    step();
    checks++;
    if (o !== 8'b0000_00_0_1) begin
      failures++;
      $display("FAIL to_err got=%b exp=%b", o, 8'b0000_00_0_1);
    end
    step();
    checks++;
    if (o !== 8'b0100_01_1_0) begin
      failures++;
      $display("FAIL to_g1 got=%b exp=%b", o, 8'b0100_01_1_0);
    end
    bus.req = 4'b1000;
    step();
    checks++;
    if (o !== 8'b0000_01_0_0) begin
      failures++;
      $display("FAIL to_rel1 got=%b exp=%b", o, 8'b0000_01_0_0);
    end
    step();
    checks++;
    if (o !== 8'b0000_01_0_0) begin
      failures++;
      $display("FAIL to_masked got=%b exp=%b", o, 8'b0000_01_0_0);
    end
    bus.req = 4'b0000;
    step();
    bus.req = 4'b1000;
    step();
    checks++;
    if (o !== 8'b1000_00_1_0) begin
      failures++;
      $display("FAIL to_regnt got=%b exp=%b", o, 8'b1000_00_1_0);
    end
  endtask
`else
  task automatic test_unbounded();
    do_reset();
    bus.rr_mode = 1'b0;
    bus.req = 4'b1100;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (o !== 8'b1000_00_1_0) begin
        failures++;
        $display("FAIL unb_own%0d got=%b exp=%b", i, o, 8'b1000_00_1_0);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.rr_mode = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_wrap();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
